// File: rtl/hazard_fwd_ctrl.sv
// Hazard, forwarding and fetch-sequencing controller for the 3-stage (IF/D, EX, WB) RV32 pipeline.
// Optional macro PERF_CNT_EN adds the cycle_cnt / instret_cnt performance counters.
module hazard_fwd_ctrl #(
  parameter logic [3:0] BIOS_REGION = 4'h4,
  parameter logic [3:0] IMEM_REGION = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_raw,
  input  logic [31:0] pc_d,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        fa_1,
  output logic        fb_1,
  output logic        fa_2,
  output logic        fb_2,
  output logic [1:0]  pc_sel,
  output logic [1:0]  inst_sel,
  output logic        br_un,
  output logic        reg_wr_en,
  output logic        flush
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {CLS_NONE, CLS_BRANCH, CLS_JUMP} cls_t;
  typedef enum logic [1:0] {ST_RST, ST_BUBBLE, ST_RUN} state_t;

  state_t      state;
  logic        ex_valid, ex_wr, ex_use1, ex_use2;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [2:0]  ex_funct3;
  cls_t        ex_cls;
  logic        wb_wr;
  logic [4:0]  wb_rd;

  logic        wr_d, use1_d, use2_d;
  cls_t        cls_d;
  logic        cond, taken, startup;

  // Only opcode/register/funct3 fields matter here; the remaining bits are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{inst_raw[31:25], pc_d[27:0]};

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_d   = 1'b0;
    use1_d = 1'b0;
    use2_d = 1'b0;
    cls_d  = CLS_NONE;
    case (inst_raw[6:0])
      OPC_OP:              begin wr_d = 1'b1; use1_d = 1'b1; use2_d = 1'b1; end
      OPC_OPIMM, OPC_LOAD: begin wr_d = 1'b1; use1_d = 1'b1; end
      OPC_LUI, OPC_AUIPC:  wr_d = 1'b1;
      OPC_JAL:             begin wr_d = 1'b1; cls_d = CLS_JUMP; end
      OPC_JALR:            begin wr_d = 1'b1; use1_d = 1'b1; cls_d = CLS_JUMP; end
      OPC_STORE:           begin use1_d = 1'b1; use2_d = 1'b1; end
      OPC_BRANCH:          begin use1_d = 1'b1; use2_d = 1'b1; cls_d = CLS_BRANCH; end
      OPC_SYSTEM:          use1_d = (inst_raw[14:12] == 3'b001);
      default:             ;
    endcase
    // x0 is never a real destination, which also keeps it out of every forwarding path.
    if (inst_raw[11:7] == 5'd0) wr_d = 1'b0;
  end

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:          cond = br_eq;
      3'b001:          cond = ~br_eq;
      3'b100, 3'b110:  cond = br_lt;
      3'b101, 3'b111:  cond = ~br_lt;
      default:         cond = 1'b0;
    endcase
    taken   = ex_valid & ((ex_cls == CLS_JUMP) | ((ex_cls == CLS_BRANCH) & cond));
    startup = (state != ST_RUN);
  end

  always_comb begin
    pc_sel   = 2'd0;
    inst_sel = 2'd2;
    if (taken)        pc_sel = 2'd1;
    else if (startup) pc_sel = 2'd2;
    if (!(taken || startup)) begin
      if (pc_d[31:28] == BIOS_REGION)      inst_sel = 2'd1;
      else if (pc_d[31:28] == IMEM_REGION) inst_sel = 2'd0;
      else                                 inst_sel = 2'd2;
    end
  end

  assign flush     = taken;
  assign br_un     = ex_funct3[1];
  assign reg_wr_en = wb_wr;
  assign fa_1      = wb_wr & (wb_rd == inst_raw[19:15]) & use1_d;
  assign fb_1      = wb_wr & (wb_rd == inst_raw[24:20]) & use2_d;
  assign fa_2      = wb_wr & (wb_rd == ex_rs1) & ex_use1;
  assign fb_2      = wb_wr & (wb_rd == ex_rs2) & ex_use2;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RST;
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_use1   <= 1'b0;
      ex_use2   <= 1'b0;
      ex_rd     <= 5'd0;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      ex_funct3 <= 3'd0;
      ex_cls    <= CLS_NONE;
      wb_wr     <= 1'b0;
      wb_rd     <= 5'd0;
    end else begin
      case (state)
        ST_RST:    state <= ST_BUBBLE;
        ST_BUBBLE: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase

      // The EX instruction retires even when it is the one killing D (e.g. JAL writing rd).
      wb_wr <= ex_wr & ex_valid;
      wb_rd <= ex_rd;

      if (taken || startup) begin
        ex_valid  <= 1'b0;
        ex_wr     <= 1'b0;
        ex_use1   <= 1'b0;
        ex_use2   <= 1'b0;
        ex_rd     <= 5'd0;
        ex_rs1    <= 5'd0;
        ex_rs2    <= 5'd0;
        ex_funct3 <= 3'd0;
        ex_cls    <= CLS_NONE;
      end else begin
        ex_valid  <= 1'b1;
        ex_wr     <= wr_d;
        ex_use1   <= use1_d;
        ex_use2   <= use2_d;
        ex_rd     <= inst_raw[11:7];
        ex_rs1    <= inst_raw[19:15];
        ex_rs2    <= inst_raw[24:20];
        ex_funct3 <= inst_raw[14:12];
        ex_cls    <= cls_d;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state == ST_RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (ex_valid)        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
